sram_dp_be: RTL

Parametrised simple-dual-port synchronous SRAM with per-byte write enables, registered one-cycle read, write-first collision forwarding and a hardware clear sequencer that initialises every word after reset. It is the next generation of the team's single-port SRAM in the memory-design library. It serves as the storage core for FIFOs, register files and line buffers that need a concurrent read and write each cycle.

---
 rtl/sram_dp_be_if.sv | 35 +++
 rtl/sram_dp_be.sv | 105 ++++++++++
 2 files changed

// File: rtl/sram_dp_be_if.sv
// Port bundle for the simple-dual-port byte-enable SRAM.
//
// Handshake: there is no back-pressure. wr_en / rd_en are requests that the
// memory accepts on the rising edge whenever init_busy is low. Requests seen
// while init_busy is high are discarded. Each accepted read produces exactly
// one rd_valid pulse, one cycle later, with rd_data / rd_err qualified by it.
interface sram_dp_be_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 8
);
  localparam int NUM_BYTES = WORD_WIDTH / 8;

  logic                  init_busy;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_BYTES-1:0]  wr_be;
  logic [WORD_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_err;

  // Requester side.
  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  init_busy, rd_data, rd_valid, rd_err
  );

  // Memory side.
  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output init_busy, rd_data, rd_valid, rd_err
  );
endinterface

// File: rtl/sram_dp_be.sv
// Simple-dual-port synchronous SRAM with per-byte write enables, registered
// one-cycle read, write-first forwarding on same-address collisions and a
// clear sequencer that writes INIT_VALUE to every word after reset.
module sram_dp_be #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    WORD_DEPTH = 16,
  parameter int                    WORD_WIDTH = 8,
  parameter logic [WORD_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  sram_dp_be_if.slave  bus,
  output logic         fsm_state   // 0 = INIT, 1 = READY
);

  localparam int NUM_BYTES = WORD_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [WORD_WIDTH-1:0] mem [WORD_DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_fire;
  logic                  collide;
  logic [WORD_WIDTH-1:0] rd_word;

  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);
  assign wr_fire     = (state_q == READY) && bus.wr_en && wr_in_range;
  assign collide     = wr_fire && bus.rd_en && (bus.wr_addr == bus.rd_addr);

  assign bus.init_busy = (state_q == INIT);
  assign fsm_state     = (state_q == READY);

  // State register; reset always returns to INIT.
  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Next state: leave INIT once the last implemented word has been cleared.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (clr_cnt == LAST_ADDR) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // Clear address counter, advancing once per INIT cycle.
  always_ff @(posedge clk) begin
    if (rst)                   clr_cnt <= '0;
    else if (state_q == INIT)  clr_cnt <= clr_cnt + 1'b1;
  end

  // Storage array: clear writes during INIT, byte-masked user writes in READY.
  // The array itself is never reset; a reset edge simply performs no write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        mem[clr_cnt] <= INIT_VALUE;
      end else if (wr_fire) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (bus.wr_be[i]) mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read word with write-first forwarding of the enabled bytes on a collision.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[bus.rd_addr];
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (collide && bus.wr_be[i]) rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
  end

  // Registered read port; rd_data holds between reads, flags are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
    end else if (state_q == READY && bus.rd_en) begin
      bus.rd_valid <= 1'b1;
      bus.rd_err   <= !rd_in_range;
      bus.rd_data  <= rd_word;
    end else begin
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
    end
  end

endmodule
